// File: rtl/game_sequencer.sv
// game_sequencer
// ---------------------------------------------------------------------------
// Game-flow controller for the VGA ball game. It sequences
// start page -> serve countdown -> run -> miss pause -> game over. It also
// keeps lives, score and speed level, and gates ball motion per video frame.
//
// Ports
//   iCLK           system clock (25 MHz)
//   iRST           synchronous, active-high reset
//   iKEY_START     start-key level (asynchronous, synchronised here)
//   iVSYNC         VGA vertical sync, active-low pulse once per frame
//   iHIT           ball/paddle contact flag, high for one frame per contact
//   iMISS          ball passed the bottom edge, high for one frame
//   oDISPLAY_PAGE  0 = start page, 1 = game page, 2 = game-over page
//   oBALL_EN       ball position update enable
//   oBALL_RST      hold the ball at its launch position
//   oLIVES         remaining lives
//   oSCORE         score (binary, saturating)
//   oLEVEL         speed level 0..7
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int LIVES_INIT     = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 30,
  parameter int HITS_PER_LEVEL = 10,
  parameter int SCORE_MAX      = 9999
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iKEY_START,
  input  logic        iVSYNC,
  input  logic        iHIT,
  input  logic        iMISS,
  output logic [1:0]  oDISPLAY_PAGE,
  output logic        oBALL_EN,
  output logic        oBALL_RST,
  output logic [2:0]  oLIVES,
  output logic [13:0] oSCORE,
  output logic [2:0]  oLEVEL
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RUN   = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [2:0]  LIVES_L = 3'(LIVES_INIT);
  localparam logic [7:0]  SERVE_L = 8'(SERVE_FRAMES);
  localparam logic [7:0]  MISS_L  = 8'(MISS_FRAMES);
  localparam logic [7:0]  HPL_L   = 8'(HITS_PER_LEVEL);
  localparam logic [13:0] SMAX_L  = 14'(SCORE_MAX);

  localparam logic [1:0]  PAGE_START = 2'd0;
  localparam logic [1:0]  PAGE_GAME  = 2'd1;
  localparam logic [1:0]  PAGE_OVER  = 2'd2;

  // Bit order of the synchroniser: {miss, hit, vsync, key}.
  // The vsync chain idles high so that leaving reset never fakes a frame edge.
  localparam logic [3:0]  SYNC_INIT = 4'b0010;

  logic [3:0] sync_in;
  logic [3:0] sync_out;

  assign sync_in = {iMISS, iHIT, iVSYNC, iKEY_START};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          s1_reg <= SYNC_INIT[gi];
          s2_reg <= SYNC_INIT[gi];
        end else begin
          s1_reg <= sync_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_out[gi] = s2_reg;
    end
  endgenerate

  logic key_s, vsync_s, hit_s, miss_s;
  assign key_s   = sync_out[0];
  assign vsync_s = sync_out[1];
  assign hit_s   = sync_out[2];
  assign miss_s  = sync_out[3];

  logic key_d_reg;
  logic vsync_d_reg;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      key_d_reg   <= 1'b0;
      vsync_d_reg <= 1'b1;
    end else begin
      key_d_reg   <= key_s;
      vsync_d_reg <= vsync_s;
    end
  end

  logic start_pulse;
  logic frame_tick;
  assign start_pulse = key_s & ~key_d_reg;
  assign frame_tick  = vsync_d_reg & ~vsync_s;

  // State and datapath registers
  state_t      state_reg,     state_next;
  logic [7:0]  frame_cnt_reg, frame_cnt_next;
  logic [7:0]  hit_cnt_reg,   hit_cnt_next;
  logic [2:0]  lives_reg,     lives_next;
  logic [13:0] score_reg,     score_next;
  logic [2:0]  level_reg,     level_next;
  logic [1:0]  page_reg,      page_next;
  logic        ball_en_reg,   ball_en_next;
  logic        ball_rst_reg,  ball_rst_next;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= 8'd0;
      hit_cnt_reg   <= 8'd0;
      lives_reg     <= 3'd0;
      score_reg     <= 14'd0;
      level_reg     <= 3'd0;
      page_reg      <= PAGE_START;
      ball_en_reg   <= 1'b0;
      ball_rst_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      hit_cnt_reg   <= hit_cnt_next;
      lives_reg     <= lives_next;
      score_reg     <= score_next;
      level_reg     <= level_next;
      page_reg      <= page_next;
      ball_en_reg   <= ball_en_next;
      ball_rst_reg  <= ball_rst_next;
    end
  end

  // The frame counter never exceeds its limit minus one, so the 8-bit
  // increment cannot wrap before it is compared.
  logic [7:0] frame_inc;
  logic [7:0] hit_inc;
  assign frame_inc = frame_cnt_reg + 8'd1;
  assign hit_inc   = hit_cnt_reg + 8'd1;

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    hit_cnt_next   = hit_cnt_reg;
    lives_next     = lives_reg;
    score_next     = score_reg;
    level_next     = level_reg;

    unique case (state_reg)
      IDLE, OVER: begin
        // A frame tick coinciding with the start pulse is deliberately not
        // counted: the serve countdown starts from zero.
        if (start_pulse) begin
          lives_next     = LIVES_L;
          score_next     = 14'd0;
          level_next     = 3'd0;
          hit_cnt_next   = 8'd0;
          frame_cnt_next = 8'd0;
          state_next     = SERVE;
        end
      end

      SERVE: begin
        if (frame_tick) begin
          if (frame_inc == SERVE_L) begin
            frame_cnt_next = 8'd0;
            state_next     = RUN;
          end else begin
            frame_cnt_next = frame_inc;
          end
        end
      end

      RUN: begin
        if (frame_tick) begin
          if (miss_s) begin
            // A miss wins over a same-frame hit; that hit is dropped.
            lives_next = lives_reg - 3'd1;
            if (lives_reg == 3'd1) begin
              state_next = OVER;
            end else begin
              frame_cnt_next = 8'd0;
              state_next     = MISS;
            end
          end else if (hit_s) begin
            if (score_reg < SMAX_L) begin
              score_next = score_reg + 14'd1;
            end
            if (hit_inc == HPL_L) begin
              hit_cnt_next = 8'd0;
              if (level_reg != 3'd7) begin
                level_next = level_reg + 3'd1;
              end
            end else begin
              hit_cnt_next = hit_inc;
            end
          end
        end
      end

      MISS: begin
        if (frame_tick) begin
          if (frame_inc == MISS_L) begin
            frame_cnt_next = 8'd0;
            state_next     = SERVE;
          end else begin
            frame_cnt_next = frame_inc;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so that they change on the same
  // edge as the state register.
  always_comb begin
    page_next     = PAGE_GAME;
    ball_en_next  = 1'b0;
    ball_rst_next = 1'b1;
    unique case (state_next)
      IDLE:    page_next = PAGE_START;
      OVER:    page_next = PAGE_OVER;
      RUN: begin
        ball_en_next  = 1'b1;
        ball_rst_next = 1'b0;
      end
      default: page_next = PAGE_GAME;
    endcase
  end

  assign oDISPLAY_PAGE = page_reg;
  assign oBALL_EN      = ball_en_reg;
  assign oBALL_RST     = ball_rst_reg;
  assign oLIVES        = lives_reg;
  assign oSCORE        = score_reg;
  assign oLEVEL        = level_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
// Directed bench for game_sequencer with default parameters. Frames are
// produced by the bench as 4-cycle vsync periods; hit/miss are held across
// the frame edge so the synchronised samples line up with the frame tick.
module tb_game_sequencer;

  logic        clk;
  logic        rst;
  logic        key;
  logic        vsync;
  logic        hit;
  logic        miss;
  logic [1:0]  page;
  logic        ball_en;
  logic        ball_rst;
  logic [2:0]  lives;
  logic [13:0] score;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  game_sequencer dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iKEY_START    (key),
    .iVSYNC        (vsync),
    .iHIT          (hit),
    .iMISS         (miss),
    .oDISPLAY_PAGE (page),
    .oBALL_EN      (ball_en),
    .oBALL_RST     (ball_rst),
    .oLIVES        (lives),
    .oSCORE        (score),
    .oLEVEL        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One video frame; returns after the tick has been registered.
  task automatic frame(input logic h, input logic m);
    hit  = h;
    miss = m;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
  endtask

  task automatic press(input int n);
    key = 1'b1;
    repeat (n) @(negedge clk);
    key = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_page"},  16'(page),     16'd0);
    check({tag, "_en"},    16'(ball_en),  16'd0);
    check({tag, "_brst"},  16'(ball_rst), 16'd1);
    check({tag, "_lives"}, 16'(lives),    16'd0);
    check({tag, "_score"}, 16'(score),    16'd0);
    check({tag, "_level"}, 16'(level),    16'd0);
  endtask

  initial begin
    rst   = 1'b1;
    key   = 1'b0;
    vsync = 1'b1;
    hit   = 1'b0;
    miss  = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");
    $display("step reset: page=%0d en=%0d lives=%0d", page, ball_en, lives);

    // Start and serve countdown
    press(1);
    check("start_page",  16'(page),     16'd1);
    check("start_lives", 16'(lives),    16'd3);
    check("start_brst",  16'(ball_rst), 16'd1);
    frames(59);
    check("serve59_en",  16'(ball_en),  16'd0);
    frame(1'b0, 1'b0);
    check("serve60_en",   16'(ball_en),  16'd1);
    check("serve60_brst", 16'(ball_rst), 16'd0);
    $display("step serve: en=%0d brst=%0d", ball_en, ball_rst);

    // Hits and level increments
    for (int i = 0; i < 9; i++) frame(1'b1, 1'b0);
    check("hit9_level", 16'(level), 16'd0);
    frame(1'b1, 1'b0);
    check("hit10_level", 16'(level), 16'd1);
    for (int i = 0; i < 9; i++) frame(1'b1, 1'b0);
    check("hit19_level", 16'(level), 16'd1);
    frame(1'b1, 1'b0);
    check("hit20_level", 16'(level), 16'd2);
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b0);
    check("hit25_score", 16'(score), 16'd25);
    check("hit25_level", 16'(level), 16'd2);
    $display("step hits: score=%0d level=%0d", score, level);

    // Start in RUN is ignored
    press(1);
    check("run_start_lives", 16'(lives),   16'd3);
    check("run_start_en",    16'(ball_en), 16'd1);

    // Hit and miss in the same frame: miss wins
    frame(1'b1, 1'b1);
    check("hm_lives", 16'(lives),   16'd2);
    check("hm_score", 16'(score),   16'd25);
    check("hm_en",    16'(ball_en), 16'd0);
    check("hm_page",  16'(page),    16'd1);
    frame(1'b1, 1'b1);                 // ignored in MISS but counts as a frame
    frames(28);
    check("miss29_lives", 16'(lives),    16'd2);
    check("miss29_score", 16'(score),    16'd25);
    check("miss29_brst",  16'(ball_rst), 16'd1);
    frame(1'b0, 1'b0);
    frames(59);
    check("reserve59_en", 16'(ball_en), 16'd0);
    frame(1'b0, 1'b0);
    check("reserve60_en", 16'(ball_en), 16'd1);
    $display("step miss pause: lives=%0d en=%0d", lives, ball_en);

    // Remaining misses to game over
    frame(1'b0, 1'b1);
    check("miss2_lives", 16'(lives), 16'd1);
    frames(30);
    frames(60);
    check("miss2_run_en", 16'(ball_en), 16'd1);
    frame(1'b0, 1'b1);
    check("over_lives", 16'(lives),    16'd0);
    check("over_page",  16'(page),     16'd2);
    check("over_en",    16'(ball_en),  16'd0);
    check("over_brst",  16'(ball_rst), 16'd1);
    check("over_score", 16'(score),    16'd25);
    check("over_level", 16'(level),    16'd2);
    frame(1'b1, 1'b0);
    check("over_frozen_score", 16'(score), 16'd25);
    $display("step game over: page=%0d score=%0d", page, score);

    // Held start key: one restart
    press(100);
    check("restart_page",  16'(page),  16'd1);
    check("restart_lives", 16'(lives), 16'd3);
    check("restart_score", 16'(score), 16'd0);
    check("restart_level", 16'(level), 16'd0);
    frames(60);
    check("restart_run_en", 16'(ball_en), 16'd1);
    $display("step restart: page=%0d lives=%0d", page, lives);

    // Score and level saturation
    for (int i = 0; i < 9999; i++) frame(1'b1, 1'b0);
    check("sat_score", 16'(score), 16'd9999);
    check("sat_level", 16'(level), 16'd7);
    frame(1'b1, 1'b0);
    check("sat_score_hold", 16'(score), 16'd9999);
    $display("step saturation: score=%0d level=%0d", score, level);

    // Reset during RUN
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("run_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("step run reset: page=%0d en=%0d", page, ball_en);

    // Start pulse and frame tick coincide in IDLE: that tick is not counted
    key   = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    key = 1'b0;
    repeat (2) @(negedge clk);
    check("coin_page",  16'(page),  16'd1);
    check("coin_lives", 16'(lives), 16'd3);
    frames(59);
    check("coin59_en", 16'(ball_en), 16'd0);
    frame(1'b0, 1'b0);
    check("coin60_en", 16'(ball_en), 16'd1);
    $display("step coincident start/tick: en=%0d", ball_en);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
